// File: rtl/uart_pkg.sv
// Shared definitions for the UART FIFO relay: default word width, relay state
// encoding, and the byte transform applied between the RX and TX FIFOs.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned RELAY_STATE_W   = 3;
  localparam int unsigned XFORM_W         = 32;

  typedef enum logic [RELAY_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LAT   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } relay_state_e;

  // Additive transform; callers truncate the result to their word width.
  function automatic logic [XFORM_W-1:0] xform(input logic [XFORM_W-1:0] data,
                                               input logic [XFORM_W-1:0] add_const);
    return data + add_const;
  endfunction

endpackage

// File: rtl/uart_fifo_relay_if.sv
// FIFO-side handshake bundle between the relay (master) and the RX/TX FIFOs (slave).
interface uart_fifo_relay_if #(
  parameter int unsigned DATA_WIDTH = uart_pkg::UART_DATA_WIDTH
);
  logic                  rx_empty;
  logic                  rx_rd_en;
  logic [DATA_WIDTH-1:0] rx_dout;
  logic                  tx_full;
  logic                  tx_wr_en;
  logic [DATA_WIDTH-1:0] tx_din;

  modport master (
    input  rx_empty, rx_dout, tx_full,
    output rx_rd_en, tx_wr_en, tx_din
  );

  modport slave (
    output rx_empty, rx_dout, tx_full,
    input  rx_rd_en, tx_wr_en, tx_din
  );
endinterface

// File: rtl/uart_fifo_relay.sv
// Moves bytes from the RX FIFO to the TX FIFO one at a time, adding ADD_CONST
// to each; read data is sampled READ_LATENCY cycles after the read strobe.
module uart_fifo_relay
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int unsigned ADD_CONST    = 1,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 enable,
  uart_fifo_relay_if.master    fifo,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] byte_count
);

  localparam int unsigned LAT_W = 2;

  relay_state_e          state;
  logic [LAT_W-1:0]      lat_cnt;
  logic [DATA_WIDTH-1:0] data_reg;

  // Relay FSM with registered strobes, data and status.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state         <= ST_IDLE;
      fifo.rx_rd_en <= 1'b0;
      fifo.tx_wr_en <= 1'b0;
      fifo.tx_din   <= '0;
      busy          <= 1'b0;
      byte_count    <= '0;
      lat_cnt       <= '0;
      data_reg      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (enable && !fifo.rx_empty) begin
            fifo.rx_rd_en <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_READ;
          end
        end
        ST_READ: begin
          fifo.rx_rd_en <= 1'b0;
          lat_cnt       <= LAT_W'(READ_LATENCY - 1);
          state         <= ST_LAT;
        end
        ST_LAT: begin
          if (lat_cnt == '0) begin
            data_reg <= DATA_WIDTH'(xform(XFORM_W'(fifo.rx_dout), XFORM_W'(ADD_CONST)));
            state    <= ST_WRITE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_WRITE: begin
          // Stalls here for as long as the TX FIFO reports full.
          if (!fifo.tx_full) begin
            fifo.tx_wr_en <= 1'b1;
            fifo.tx_din   <= data_reg;
            byte_count    <= byte_count + CNT_WIDTH'(1);
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          fifo.tx_wr_en <= 1'b0;
          busy          <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          fifo.rx_rd_en <= 1'b0;
          fifo.tx_wr_en <= 1'b0;
          busy          <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_relay.sv
// Bench for uart_fifo_relay: two relays (ADD_CONST 1 / 0x10) share one RX FIFO
// model and TX backpressure; a timeline model predicts every output each cycle.
module tb_uart_fifo_relay;
  import uart_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned RL  = 1;
  localparam int unsigned K1  = 1;
  localparam int unsigned K2  = 16;
  localparam int unsigned CW1 = 16;
  localparam int unsigned CW2 = 4;

  logic           clk_in = 1'b0;
  logic           rst    = 1'b1;
  logic           enable = 1'b0;
  logic           busy1, busy2;
  logic [CW1-1:0] cnt1;
  logic [CW2-1:0] cnt2;

  logic           empty_q = 1'b1;
  logic           full_q  = 1'b0;
  logic [7:0]     pipe [3] = '{default: 8'h00};
  logic [7:0]     fq[$];
  logic [7:0]     fv;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit started = 1'b0;

  uart_fifo_relay_if #(.DATA_WIDTH(DW)) f1();
  uart_fifo_relay_if #(.DATA_WIDTH(DW)) f2();

  assign f1.rx_empty = empty_q;
  assign f1.rx_dout  = pipe[RL-1];
  assign f1.tx_full  = full_q;
  assign f2.rx_empty = empty_q;
  assign f2.rx_dout  = pipe[RL-1];
  assign f2.tx_full  = full_q;

  uart_fifo_relay #(.DATA_WIDTH(DW), .ADD_CONST(K1), .READ_LATENCY(RL), .CNT_WIDTH(CW1)) dut1 (
    .clk_in(clk_in), .rst(rst), .enable(enable), .fifo(f1), .busy(busy1), .byte_count(cnt1));
  uart_fifo_relay #(.DATA_WIDTH(DW), .ADD_CONST(K2), .READ_LATENCY(RL), .CNT_WIDTH(CW2)) dut2 (
    .clk_in(clk_in), .rst(rst), .enable(enable), .fifo(f2), .busy(busy2), .byte_count(cnt2));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
    end
  endfunction

  // RX FIFO model: empty flag lags one cycle, data appears RL cycles after the strobe edge.
  always @(posedge clk_in) begin
    empty_q <= (fq.size() == 0);
    if (f1.rx_rd_en === 1'b1) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL over_read actual=empty_fifo_read expected=no_read t=%0t", $time);
      end else begin
        fv = fq.pop_front();
        pipe[0] <= fv;
      end
    end
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end

  // Timeline model: m_t counts edges since the read was issued (-1 when idle).
  int         m_t = -1;
  logic [7:0] mq[$];
  logic [7:0] m_val = 8'h00, m_data1 = 8'h00, m_data2 = 8'h00;
  logic       e_rd = 1'b0, e_wr = 1'b0, e_busy = 1'b0;
  logic [7:0] e_din1 = 8'h00, e_din2 = 8'h00;
  int         e_cnt = 0;

  always @(posedge clk_in) begin
    if (rst) begin
      m_t = -1; e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0;
      e_din1 = 8'h00; e_din2 = 8'h00; e_cnt = 0;
    end else if (m_t < 0) begin
      if (enable && !empty_q) begin
        m_t = 0; e_rd = 1'b1; e_busy = 1'b1;
        m_val = (mq.size() != 0) ? mq.pop_front() : 8'h00;
      end
    end else begin
      m_t++;
      if (m_t == 1) e_rd = 1'b0;
      if (m_t == 1 + RL) begin
        m_data1 = 8'((int'(m_val) + K1) % 256);
        m_data2 = 8'((int'(m_val) + K2) % 256);
      end
      if (e_wr) begin
        e_wr = 1'b0; e_busy = 1'b0; m_t = -1;
      end else if (m_t >= 2 + RL && !full_q) begin
        e_wr = 1'b1; e_din1 = m_data1; e_din2 = m_data2; e_cnt++;
      end
    end
  end

  // Per-cycle compare plus event logging for the directed checks.
  int rcyc[$];
  int wcyc[$];
  logic [7:0] wd1[$], wd2[$];

  always @(negedge clk_in) begin
    if (started) begin
      chk("rd_en1", 32'(f1.rx_rd_en), 32'(e_rd));
      chk("rd_en2", 32'(f2.rx_rd_en), 32'(e_rd));
      chk("wr_en1", 32'(f1.tx_wr_en), 32'(e_wr));
      chk("wr_en2", 32'(f2.tx_wr_en), 32'(e_wr));
      chk("din1",   32'(f1.tx_din),   32'(e_din1));
      chk("din2",   32'(f2.tx_din),   32'(e_din2));
      chk("busy1",  32'(busy1),       32'(e_busy));
      chk("busy2",  32'(busy2),       32'(e_busy));
      chk("cnt1",   32'(cnt1),        32'(e_cnt % 65536));
      chk("cnt2",   32'(cnt2),        32'(e_cnt % 16));
      if (f1.rx_rd_en === 1'b1) rcyc.push_back(cyc);
      if (f1.tx_wr_en === 1'b1) begin
        wcyc.push_back(cyc);
        wd1.push_back(f1.tx_din);
        wd2.push_back(f2.tx_din);
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    mq.push_back(b);
  endtask

  task automatic clear_log();
    rcyc.delete(); wcyc.delete(); wd1.delete(); wd2.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (3) @(negedge clk_in);
    while ((fq.size() != 0 || busy1 !== 1'b0 || empty_q !== 1'b1) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_idle actual=timeout expected=idle_within_%0d t=%0t", budget, $time);
    end
    repeat (2) @(negedge clk_in);
  endtask

  int rel;

  initial begin
    repeat (3) @(negedge clk_in);
    started = 1'b1;
    chk("rst_rd_en", 32'(f1.rx_rd_en), 32'h0);
    chk("rst_wr_en", 32'(f1.tx_wr_en), 32'h0);
    chk("rst_din",   32'(f1.tx_din),   32'h0);
    chk("rst_busy",  32'(busy1),       32'h0);
    chk("rst_cnt",   32'(cnt1),        32'h0);
    rst = 1'b0;

    // Single byte
    clear_log();
    push(8'h41); enable = 1'b1;
    wait_idle(50);
    chk("single_nwr", 32'(wcyc.size()), 32'd1);
    chk("single_nrd", 32'(rcyc.size()), 32'd1);
    if (wcyc.size() == 1 && rcyc.size() == 1) begin
      chk("single_din1", 32'(wd1[0]), 32'h42);
      chk("single_din2", 32'(wd2[0]), 32'h51);
      chk("single_lag",  32'(wcyc[0] - rcyc[0]), 32'd3);
    end
    chk("single_cnt",  32'(cnt1),  32'd1);
    chk("single_busy", 32'(busy1), 32'd0);

    // Arithmetic wrap
    clear_log();
    push(8'hFF); push(8'hF8);
    wait_idle(60);
    chk("wrap_nwr", 32'(wcyc.size()), 32'd2);
    if (wcyc.size() == 2) begin
      chk("wrap_ff_k1",  32'(wd1[0]), 32'h00);
      chk("wrap_ff_k16", 32'(wd2[0]), 32'h0F);
      chk("wrap_f8_k1",  32'(wd1[1]), 32'hF9);
      chk("wrap_f8_k16", 32'(wd2[1]), 32'h08);
    end

    // Backpressure: full held well beyond WRITE entry
    clear_log();
    full_q = 1'b1;
    push(8'h7E);
    repeat (16) @(negedge clk_in);
    chk("bp_blocked", 32'(wcyc.size()), 32'd0);
    full_q = 1'b0;
    rel = cyc;
    wait_idle(40);
    chk("bp_nwr", 32'(wcyc.size()), 32'd1);
    if (wcyc.size() == 1) begin
      chk("bp_din",   32'(wd1[0]),  32'h7F);
      chk("bp_first", 32'(wcyc[0]), 32'(rel + 1));
    end

    // Burst with lagging empty flag
    clear_log();
    push(8'h10); push(8'h20); push(8'h30);
    wait_idle(80);
    chk("burst_nrd", 32'(rcyc.size()), 32'd3);
    chk("burst_nwr", 32'(wcyc.size()), 32'd3);
    if (wcyc.size() == 3) begin
      chk("burst_d0", 32'(wd1[0]), 32'h11);
      chk("burst_d1", 32'(wd1[1]), 32'h21);
      chk("burst_d2", 32'(wd1[2]), 32'h31);
      chk("burst_gap0", 32'(wcyc[1] - wcyc[0]), 32'd5);
      chk("burst_gap1", 32'(wcyc[2] - wcyc[1]), 32'd5);
    end
    chk("burst_cnt1", 32'(cnt1), 32'd7);
    chk("burst_cnt2", 32'(cnt2), 32'd7);

    // Enable low with data waiting
    clear_log();
    enable = 1'b0;
    push(8'h55);
    repeat (20) @(negedge clk_in);
    chk("dis_nrd", 32'(rcyc.size()), 32'd0);
    enable = 1'b1;
    wait_idle(40);
    chk("dis_nwr", 32'(wcyc.size()), 32'd1);
    if (wcyc.size() == 1) chk("dis_din", 32'(wd1[0]), 32'h56);

    // Reset while waiting for read data
    clear_log();
    push(8'h99);
    begin
      int n = 0;
      while (rcyc.size() == 0 && n < 20) begin
        @(negedge clk_in);
        n++;
      end
      chk("rstlat_rd_seen", 32'(rcyc.size()), 32'd1);
    end
    @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    chk("rstlat_rd",   32'(f1.rx_rd_en), 32'h0);
    chk("rstlat_wr",   32'(f1.tx_wr_en), 32'h0);
    chk("rstlat_cnt",  32'(cnt1),        32'h0);
    chk("rstlat_busy", 32'(busy1),       32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk_in);
    chk("rstlat_nwr", 32'(wcyc.size()), 32'd0);

    // Randomised traffic with backpressure and enable toggling
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if (fq.size() < 8 && ($urandom % 3) == 0) push(8'($urandom));
      enable = (($urandom % 8) != 0);
      full_q = (($urandom % 4) == 0);
    end
    enable = 1'b1;
    full_q = 1'b0;
    wait_idle(300);
    chk("final_model_drained", 32'(mq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_relay.md
Name: uart_fifo_relay

Overview:
Drains bytes from the receive-side FIFO of uart_with_fifo_rx, applies a fixed additive transform, and pushes the results into the transmit-side FIFO of uart_with_fifo_tx. It is the writer/reader counterpart that closes the RX→TX loop in hardware. It replaces the ad-hoc reader/processor logic currently held in benches. It sits between the two FIFO-wrapped UART blocks in the echo/loopback top level.

Parameters:
DATA_WIDTH, 8, width of FIFO data words
ADD_CONST, 1, value added to every byte, modulo 2^DATA_WIDTH
READ_LATENCY, 1, cycles from rx_rd_en high to valid rx_dout (range 1..3)
CNT_WIDTH, 16, width of byte_count

Ports:
clk_in  input  1  system clock
rst  input  1  synchronous active-high reset
enable  input  1  relay permitted to start a new byte
rx_empty  input  1  RX FIFO empty flag
rx_rd_en  output  1  RX FIFO read strobe, single-cycle pulse
rx_dout  input  DATA_WIDTH  RX FIFO read data
tx_full  input  1  TX FIFO full flag
tx_wr_en  output  1  TX FIFO write strobe, single-cycle pulse
tx_din  output  DATA_WIDTH  TX FIFO write data
busy  output  1  high in any state other than IDLE
byte_count  output  CNT_WIDTH  bytes written to TX FIFO since reset, wraps at 2^CNT_WIDTH

Behaviour:
- Clock and reset: single clock clk_in. Reset is synchronous and active-high on rst.
- Reset values: rx_rd_en=0, tx_wr_en=0, tx_din=0, busy=0, byte_count=0, state=IDLE, latency counter=0, data register=0.
- All outputs are registered.
- FSM states: IDLE, READ, LAT, WRITE, DONE.
- IDLE: if enable=1 and rx_empty=0 on edge E, then at E: rx_rd_en<=1 and state<=READ. Otherwise stay in IDLE.
- READ (one cycle): rx_rd_en<=0; latency counter<=READ_LATENCY-1; state<=LAT.
- LAT: rx_dout is sampled at the edge that lies READ_LATENCY cycles after the edge where rx_rd_en was high.
  - Captured value: data_reg<=(rx_dout+ADD_CONST) truncated to DATA_WIDTH.
  - Then state<=WRITE. While the counter is nonzero, decrement it and stay in LAT.
- WRITE: if tx_full=0, then tx_wr_en<=1, tx_din<=data_reg, byte_count<=byte_count+1, state<=DONE.
  - If tx_full=1, stay in WRITE with tx_wr_en=0 and data_reg held, indefinitely.
- DONE (one cycle): tx_wr_en<=0; state<=IDLE.
  - This guarantees at least 3 cycles between successive rx_rd_en pulses, so a stale rx_empty=0 that lags one cycle after the last read cannot cause an over-read.
- Timing with READ_LATENCY=1: rx_rd_en is high in cycle 1 after the empty sample, tx_wr_en is high in cycle 4, and the next rx_rd_en is earliest in cycle 6. That is one byte per 5 cycles, well above UART rate.
- enable deasserted mid-byte: the current byte completes through DONE; no new read starts.
- rx_empty rising after rx_rd_en: ignored; a read already issued always completes.
- Simultaneous tx_full rise and WRITE entry: the sampled tx_full value decides; with full=1 there is no write.
- Arithmetic wrap: 0xFF+1 gives 0x00. byte_count wraps silently.
- Reset mid-operation: all outputs drop to reset values at the next edge. An in-flight byte is discarded and the FIFOs are not touched further.
- busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg holds:
  - DATA_WIDTH default
  - relay state encoding constants (IDLE=0, READ=1, LAT=2, WRITE=3, DONE=4, 3 bits)
  - an xform function (add-constant with truncation), so later transforms stay in one place.
- No sub-module: a single FSM plus datapath register is natural. The FIFOs and UARTs stay external.

Test Plan:
- Single byte: RX FIFO holds 0x41, enable=1 → one rx_rd_en pulse; one tx_wr_en pulse 3 cycles later with tx_din=0x42; byte_count=1; busy low afterwards.
- Wrap: RX byte 0xFF, ADD_CONST=1 → tx_din=0x00. Separately, ADD_CONST=0x10 with byte 0xF8 → tx_din=0x08.
- Backpressure: tx_full=1 for 10 cycles when WRITE is entered → no tx_wr_en and data held; tx_wr_en pulses on the first edge after tx_full=0 with the correct byte; exactly one write.
- Burst: RX FIFO preloaded with 0x10,0x20,0x30 → TX writes 0x11,0x21,0x31 in order, 5 cycles apart; byte_count=3; no read occurs while rx_empty=1.
- Lagging empty: rx_empty stays 0 for one cycle after the last read → no extra rx_rd_en issued.
- Control: enable=0 with a non-empty FIFO → no strobes. rst asserted during LAT → rx_rd_en=tx_wr_en=0 and byte_count=0 next cycle; no write for the in-flight byte.
